// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the ALU issue/capture stage.
package alu_pkg;

    localparam logic [3:0] OPC_ADD           = 4'b0000;
    localparam logic [3:0] OPC_SUB           = 4'b0001;
    localparam logic [3:0] OPC_MUL           = 4'b0010;
    localparam logic [3:0] OPC_DIV           = 4'b0011;
    localparam logic [3:0] OPC_AND           = 4'b0100;
    localparam logic [3:0] OPC_OR            = 4'b0101;
    localparam logic [3:0] OPC_XOR           = 4'b0110;
    localparam logic [3:0] OPC_NOT           = 4'b0111;
    localparam logic [3:0] OPC_SHL           = 4'b1000;
    localparam logic [3:0] OPC_SHR           = 4'b1001;
    localparam logic [3:0] OPC_FIRST_ILLEGAL = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Only ADD and SUB report signed overflow.
    function automatic logic opc_has_ovf(input logic [3:0] op);
        return (op == OPC_ADD) || (op == OPC_SUB);
    endfunction

endpackage

// File: rtl/alu_sticky_status.sv
// Sticky {illegal, divz, ovf} status register; present only when STICKY_STATUS_EN is defined.
`ifdef STICKY_STATUS_EN
module alu_sticky_status (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_handshake,
    input  logic [2:0] i_flags,
    input  logic       i_clr,
    output logic [2:0] o_status
);

    logic [2:0] r_status;

    // Clear drops history, but a handshake in the same cycle still records its own flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= 3'b000;
        end else begin
            r_status <= (i_clr ? 3'b000 : r_status) | (i_handshake ? i_flags : 3'b000);
        end
    end

    assign o_status = r_status;

endmodule
`endif

// File: rtl/alu_issue_capture.sv
// Valid/ready stage around the combinational 8-bit ALU: registers operands, sanitises and holds results.
// Optional sticky status register enabled by defining STICKY_STATUS_EN.
module alu_issue_capture
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_divz,
    output logic              out_illegal
`ifdef STICKY_STATUS_EN
    ,
    input  logic              status_clr,
    output logic [2:0]        status
`endif
);

    state_t            r_state;
    state_t            w_next_state;
    logic              w_in_ready;
    logic              w_accept;
    logic [OP_W-1:0]   r_alu_opcode;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_y;
    logic              r_out_zero;
    logic              r_out_ovf;
    logic              r_out_divz;
    logic              r_out_illegal;
    logic [DATA_W-1:0] w_san_y;
    logic              w_san_zero;
    logic              w_san_ovf;
    logic              w_san_divz;
    logic              w_san_illegal;
    logic              w_unused_alu_zero;

    // The zero flag is recomputed from alu_y, so the ALU's own flag is never consumed.
    assign w_unused_alu_zero = alu_zero;

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                w_in_ready = out_ready;
                if (out_ready) w_next_state = in_valid ? ST_EXEC : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid && w_in_ready;

    // Divide-by-zero and illegal opcodes override whatever the ALU drove.
    always_comb begin
        w_san_y       = alu_y;
        w_san_zero    = (alu_y == '0);
        w_san_ovf     = opc_has_ovf(4'(r_alu_opcode)) && alu_overflow;
        w_san_divz    = 1'b0;
        w_san_illegal = 1'b0;
        if ((4'(r_alu_opcode) == OPC_DIV) && (r_alu_b == '0)) begin
            w_san_y    = {DATA_W{1'b1}};
            w_san_zero = 1'b0;
            w_san_ovf  = 1'b0;
            w_san_divz = 1'b1;
        end else if (4'(r_alu_opcode) >= OPC_FIRST_ILLEGAL) begin
            w_san_y       = '0;
            w_san_zero    = 1'b1;
            w_san_ovf     = 1'b0;
            w_san_illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_alu_opcode  <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_out_valid   <= 1'b0;
            r_out_y       <= '0;
            r_out_zero    <= 1'b0;
            r_out_ovf     <= 1'b0;
            r_out_divz    <= 1'b0;
            r_out_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_alu_opcode <= in_opcode;
                r_alu_a      <= in_a;
                r_alu_b      <= in_b;
            end
            if (r_state == ST_EXEC) begin
                r_out_valid   <= 1'b1;
                r_out_y       <= w_san_y;
                r_out_zero    <= w_san_zero;
                r_out_ovf     <= w_san_ovf;
                r_out_divz    <= w_san_divz;
                r_out_illegal <= w_san_illegal;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign alu_opcode  = r_alu_opcode;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign out_valid   = r_out_valid;
    assign out_y       = r_out_y;
    assign out_zero    = r_out_zero;
    assign out_ovf     = r_out_ovf;
    assign out_divz    = r_out_divz;
    assign out_illegal = r_out_illegal;

`ifdef STICKY_STATUS_EN
    alu_sticky_status u_sticky_status (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_handshake (r_out_valid && out_ready),
        .i_flags     ({r_out_illegal, r_out_divz, r_out_ovf}),
        .i_clr       (status_clr),
        .o_status    (status)
    );
`endif

endmodule
